// File: rtl/modport_counter_if.sv
// Bus bundle for the MOD12 counter: control/load inputs from the write driver,
// count back to the read side.
interface modport_counter_if;
    logic       mode;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] count;

    modport master (
        output mode,
        output load,
        output data_in,
        input  count
    );

    modport slave (
        input  mode,
        input  load,
        input  data_in,
        output count
    );
endinterface

// File: rtl/modport_counter.sv
// Modulo-12 up/down counter with parallel load and synchronous active-high reset.
// Count is registered; any value outside 0..11 collapses to 0 on the next count edge.
module modport_counter (
    input  logic               clock,
    input  logic               reset,
    modport_counter_if.slave   bus
);

    logic [3:0] r_count;
    logic [3:0] w_next;

    // Loads above 11 are clamped to 0 so the register never leaves 0..11.
    function automatic logic [3:0] clamp_load(input logic [3:0] v);
        return (v <= 4'd11) ? v : 4'd0;
    endfunction

    function automatic logic [3:0] count_up(input logic [3:0] v);
        return (v >= 4'd11) ? 4'd0 : v + 4'd1;
    endfunction

    // Zero wraps to 11; an illegal state (12..15) recovers to 0.
    function automatic logic [3:0] count_down(input logic [3:0] v);
        logic [3:0] res;
        if (v == 4'd0)
            res = 4'd11;
        else if (v > 4'd11)
            res = 4'd0;
        else
            res = v - 4'd1;
        return res;
    endfunction

    always_comb begin
        w_next = r_count;
        if (bus.load)
            w_next = clamp_load(bus.data_in);
        else if (bus.mode)
            w_next = count_up(r_count);
        else
            w_next = count_down(r_count);
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_count <= 4'd0;
        else
            r_count <= w_next;
    end

    assign bus.count = r_count;

endmodule

// File: tb/tb_modport_counter.sv
// Scoreboard bench for modport_counter: directed sequences with hand-derived
// expectations, then a long randomized run against a reference model.
module tb_modport_counter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    modport_counter_if bus ();

    modport_counter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         model = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle; want < 0 means take the reference model's prediction.
    task automatic step(input string tag, input logic r, input logic l, input logic m,
                        input logic [3:0] d, input int want);
        logic [3:0] e;
        @(negedge clock);
        reset       = r;
        bus.load    = l;
        bus.mode    = m;
        bus.data_in = d;
        if (r)
            model = 0;
        else if (l)
            model = (d > 4'd11) ? 0 : int'(d);
        else if (m)
            model = (model == 11) ? 0 : model + 1;
        else
            model = (model == 0) ? 11 : model - 1;
        if (want >= 0)
            exp_q.push_back(want[3:0]);
        else
            exp_q.push_back(model[3:0]);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {28'd0, bus.count}, {28'd0, e});
        end
        check({tag, "_range"}, {31'd0, (bus.count <= 4'd11)}, 32'd1);
    endtask

    initial begin
        bus.mode    = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 4'd0;

        // Reset dominates load and mode
        step("rst0", 1, 1, 1, 4'd7, 0);
        step("rst1", 1, 1, 1, 4'd7, 0);

        // Up wrap
        step("uw_rst", 1, 0, 0, 4'd0, 0);
        step("uw_ld9", 0, 1, 1, 4'd9, 9);
        step("uw_a",   0, 0, 1, 4'd0, 10);
        step("uw_b",   0, 0, 1, 4'd0, 11);
        step("uw_c",   0, 0, 1, 4'd0, 0);
        step("uw_d",   0, 0, 1, 4'd0, 1);

        // Down wrap
        step("dw_ld2", 0, 1, 0, 4'd2, 2);
        step("dw_a",   0, 0, 0, 4'd0, 1);
        step("dw_b",   0, 0, 0, 4'd0, 0);
        step("dw_c",   0, 0, 0, 4'd0, 11);
        step("dw_d",   0, 0, 0, 4'd0, 10);

        // Out-of-range loads clamp to 0
        step("oor13",  0, 1, 1, 4'd13, 0);
        step("oor15",  0, 1, 0, 4'd15, 0);
        step("oor_up", 0, 0, 1, 4'd0, 1);
        step("oor12",  0, 1, 1, 4'd12, 0);
        step("ld11",   0, 1, 0, 4'd11, 11);

        // Mixed control
        step("mx_ld5", 0, 1, 0, 4'd5, 5);
        step("mx_u1",  0, 0, 1, 4'd0, 6);
        step("mx_u2",  0, 0, 1, 4'd0, 7);
        step("mx_u3",  0, 0, 1, 4'd0, 8);
        step("mx_d1",  0, 0, 0, 4'd0, 7);
        step("mx_d2",  0, 0, 0, 4'd0, 6);
        step("mx_rst", 1, 0, 1, 4'd0, 0);
        step("mx_up",  0, 0, 1, 4'd0, 1);

        // Reset release into a down-count gives 11
        step("rr_rst", 1, 0, 0, 4'd0, 0);
        step("rr_dn",  0, 0, 0, 4'd0, 11);

        // Long randomized run
        for (int i = 0; i < 1000; i++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
